mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single physical memory port between instruction fetch and data load/store. It sits between the fetch and memory-access sequencing logic and the memory, and presents each side with the same read/write/resp handshake the control FSM already drives (request held until `resp`). Only one transaction is outstanding at a time. Round-robin on contention prevents starvation.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte enables

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-low (0 = reset)
- `inst_read`  input  1  fetch read request, held until `inst_resp`
- `inst_addr`  input  ADDR_W  fetch address
- `inst_rdata`  output  DATA_W  fetch read data, valid with `inst_resp`
- `inst_resp`  output  1  fetch completion pulse
- `data_read` / `data_write`  input  1  data request, held until `data_resp`
- `data_addr`  input  ADDR_W  data address
- `data_wdata`  input  DATA_W  store data
- `data_byte_enable`  input  DATA_W/8  store lane mask
- `data_rdata`  output  DATA_W  load data, valid with `data_resp`
- `data_resp`  output  1  data completion pulse
- `pmem_read` / `pmem_write`  output  1  physical request, registered
- `pmem_addr`  output  ADDR_W  registered address
- `pmem_wdata`  output  DATA_W  registered store data
- `pmem_byte_enable`  output  DATA_W/8  registered mask (all ones on reads)
- `pmem_rdata`  input  DATA_W  physical read data
- `pmem_resp`  input  1  physical completion, one cycle

## Operation
- States: IDLE, INST, DATA. Register `last_grant` (INST/DATA).
- IDLE: only `inst_read` asserted -> INST. Only `data_read|data_write` asserted -> DATA. Both asserted -> grant the side opposite `last_grant`. Neither -> stay.
- On grant, capture address, wdata, byte_enable and the op into the `pmem_*` registers. Set `last_grant`.
- INST: `pmem_read`=1. DATA: `pmem_read`=`data_read & ~data_write` and `pmem_write`=`data_write` as captured. If read and write are both asserted, the transaction is a write.
- While `pmem_resp`=1 in INST: `inst_resp`=1 and `inst_rdata`=`pmem_rdata` (combinational). Next state IDLE; `pmem_read/write` clear at that edge.
- DATA behaves the same way, using `data_resp` and `data_rdata`.
- A `*_resp` is never asserted for the side not granted. `pmem_resp` in IDLE is ignored.
- Once granted, a transaction runs to `pmem_resp` even if the requester drops its request. The response pulse is still issued.
- `*_rdata` outputs pass `pmem_rdata` through unconditionally. Consumers qualify it with `*_resp`.
- Reset (`reset`=0 at an edge): state IDLE, `last_grant`=INST (first conflict goes to data), all `pmem_*` outputs 0. Reset takes precedence mid-transaction: the in-flight access is abandoned, and a later stray `pmem_resp` is ignored.

## Timing
- Request seen in IDLE at cycle t -> `pmem_*` asserted from t+1.
- `pmem_resp` at cycle r -> requester `*_resp` at r (zero added latency on completion).
- At r+1 the state is IDLE with `pmem_read/write` low. The earliest next grant is at r+1, with `pmem_*` asserted at r+2. There is one mandatory idle cycle between transactions.
- Minimum total latency with a 1-cycle memory: request at t, resp at t+1 (memory responds the cycle it sees the request).
- `pmem_*` stay constant for the whole transaction, independent of requester input changes after the grant.

## Test plan
- Lone fetch:
  - Stimulus: `inst_read`=1, `inst_addr`=0x60, memory returns 0x00A00093 after 3 cycles.
  - Required: `pmem_read`=1 with `pmem_addr`=0x60 from t+1; `inst_resp` and `inst_rdata`=0x00A00093 in the same cycle as `pmem_resp`; `data_resp` stays 0.
- Lone store:
  - Stimulus: `data_write`=1, addr 0x100, wdata 0xDEADBEEF, mask 0011.
  - Required: `pmem_write`=1, `pmem_byte_enable`=0011, `pmem_wdata`=0xDEADBEEF; `data_resp` pulses once.
- Contention after reset:
  - Stimulus: inst and data reads both asserted and held.
  - Required: grant order DATA, INST, DATA, with one idle cycle between grants.
- Input change mid-transaction:
  - Stimulus: change `data_addr` 0x100 -> 0x200 while the DATA transaction is pending.
  - Required: `pmem_addr` holds 0x100.
- Reset mid-transaction:
  - Stimulus: `reset`=0 during INST, then `pmem_resp`=1 after release with no request pending.
  - Required: all outputs 0; no `inst_resp` is generated.
- Stray response:
  - Stimulus: `pmem_resp`=1 in IDLE.
  - Required: no `*_resp`, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one physical memory port between instruction fetch
// and data load/store; one transaction in flight, completion passed straight through.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  inst_read,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_resp,

    input  logic                  data_read,
    input  logic                  data_write,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_byte_enable,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_W-1:0]     pmem_addr,
    output logic [DATA_W-1:0]     pmem_wdata,
    output logic [DATA_W/8-1:0]   pmem_byte_enable,
    input  logic [DATA_W-1:0]     pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INST = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0]   pmem_addr_q, pmem_addr_d;
    logic [DATA_W-1:0]   pmem_wdata_q, pmem_wdata_d;
    logic [BE_W-1:0]     pmem_be_q, pmem_be_d;

    logic                inst_req_s;
    logic                data_req_s;
    logic                grant_inst_s;
    logic                grant_data_s;
    logic                done_s;

    assign inst_req_s = inst_read;
    assign data_req_s = data_read | data_write;
    assign done_s     = (state_q != ST_IDLE) && pmem_resp;

    // Grant decision: contention goes to the side that was not served last.
    always_comb begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (inst_req_s && data_req_s) begin
                if (last_grant_q == GNT_INST) begin
                    grant_data_s = 1'b1;
                end else begin
                    grant_inst_s = 1'b1;
                end
            end else if (inst_req_s) begin
                grant_inst_s = 1'b1;
            end else if (data_req_s) begin
                grant_data_s = 1'b1;
            end else begin
                grant_inst_s = 1'b0;
                grant_data_s = 1'b0;
            end
        end else begin
            grant_inst_s = 1'b0;
            grant_data_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_inst_s) begin
                    state_d      = ST_INST;
                    last_grant_d = GNT_INST;
                end else if (grant_data_s) begin
                    state_d      = ST_DATA;
                    last_grant_d = GNT_DATA;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_INST, ST_DATA: begin
                if (pmem_resp) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Physical request capture: frozen at grant, cleared on completion.
    always_comb begin
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        pmem_be_d    = pmem_be_q;
        if (grant_inst_s) begin
            pmem_read_d  = 1'b1;
            pmem_write_d = 1'b0;
            pmem_addr_d  = inst_addr;
            pmem_wdata_d = {DATA_W{1'b0}};
            pmem_be_d    = {BE_W{1'b1}};
        end else if (grant_data_s) begin
            // A simultaneous read+write request is treated as a write.
            pmem_read_d  = data_read & ~data_write;
            pmem_write_d = data_write;
            pmem_addr_d  = data_addr;
            pmem_wdata_d = data_wdata;
            pmem_be_d    = data_write ? data_byte_enable : {BE_W{1'b1}};
        end else if (done_s) begin
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
            pmem_addr_d  = {ADDR_W{1'b0}};
            pmem_wdata_d = {DATA_W{1'b0}};
            pmem_be_d    = {BE_W{1'b0}};
        end else begin
            pmem_read_d  = pmem_read_q;
            pmem_write_d = pmem_write_q;
        end
    end

    // Output logic: completion is steered only to the granted side.
    always_comb begin
        inst_resp = 1'b0;
        data_resp = 1'b0;
        case (state_q)
            ST_INST: begin
                inst_resp = pmem_resp;
            end
            ST_DATA: begin
                data_resp = pmem_resp;
            end
            ST_IDLE: begin
                inst_resp = 1'b0;
                data_resp = 1'b0;
            end
            default: begin
                inst_resp = 1'b0;
                data_resp = 1'b0;
            end
        endcase
    end

    assign inst_rdata       = pmem_rdata;
    assign data_rdata       = pmem_rdata;
    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_addr        = pmem_addr_q;
    assign pmem_wdata       = pmem_wdata_q;
    assign pmem_byte_enable = pmem_be_q;

    // State and request registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_INST;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= {ADDR_W{1'b0}};
            pmem_wdata_q <= {DATA_W{1'b0}};
            pmem_be_q    <= {BE_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            pmem_be_q    <= pmem_be_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected grants are queued when requests are
// driven and consumed when the arbiter issues the physical access and its response.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byte_enable;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    typedef struct {
        logic        is_data;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_read        (inst_read),
        .inst_addr        (inst_addr),
        .inst_rdata       (inst_rdata),
        .inst_resp        (inst_resp),
        .data_read        (data_read),
        .data_write       (data_write),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_byte_enable (data_byte_enable),
        .data_rdata       (data_rdata),
        .data_resp        (data_resp),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_addr        (pmem_addr),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input logic is_data, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] rdata);
        txn_t t;
        t.is_data = is_data;
        t.rd      = rd;
        t.wr      = wr;
        t.addr    = addr;
        t.wdata   = wdata;
        t.be      = be;
        t.rdata   = rdata;
        return t;
    endfunction

    // {read, write, addr, byte_enable, wdata}; wdata only meaningful for writes
    function automatic logic [69:0] got_vec(input logic use_wd);
        return {pmem_read, pmem_write, pmem_addr, pmem_byte_enable,
                (use_wd ? pmem_wdata : 32'h0)};
    endfunction

    function automatic logic [69:0] exp_vec(input txn_t e);
        return {e.rd, e.wr, e.addr, e.be, (e.wr ? e.wdata : 32'h0)};
    endfunction

    function automatic logic [33:0] got_resp(input logic is_data);
        return {inst_resp, data_resp, (is_data ? data_rdata : inst_rdata)};
    endfunction

    function automatic logic [33:0] exp_resp(input txn_t e);
        return {~e.is_data, e.is_data, e.rdata};
    endfunction

    task automatic idle_inputs();
        inst_read        = 1'b0;
        inst_addr        = 32'h0;
        data_read        = 1'b0;
        data_write       = 1'b0;
        data_addr        = 32'h0;
        data_wdata       = 32'h0;
        data_byte_enable = 4'h0;
        pmem_rdata       = 32'h0;
        pmem_resp        = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        inst_read  = 1'b1;
        inst_addr  = 32'h0000_0060;
        data_write = 1'b1;
        data_addr  = 32'h0000_0100;
        tick();
        tick();
        n_checks++;
        if (got_vec(1'b1) !== 70'h0) begin
            n_fail++;
            $display("FAIL reset_pmem: got %h, expected %h", got_vec(1'b1), 70'h0);
        end
        pmem_resp = 1'b1;
        #1;
        n_checks++;
        if ({inst_resp, data_resp} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_resp: got %b, expected 00", {inst_resp, data_resp});
        end
        idle_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_lone_fetch();
        txn_t e;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'hF, 32'h00A0_0093));
        inst_addr = 32'h0000_0060;
        inst_read = 1'b1;
        tick();
        e = exp_q[0];
        n_checks++;
        if (got_vec(e.wr) !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL fetch_issue: got %h, expected %h", got_vec(e.wr), exp_vec(e));
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({got_vec(e.wr), inst_resp, data_resp} !== {exp_vec(e), 2'b00}) begin
                n_fail++;
                $display("FAIL fetch_hold: got %h, expected %h",
                         {got_vec(e.wr), inst_resp, data_resp}, {exp_vec(e), 2'b00});
            end
        end
        tick();
        pmem_rdata = 32'h00A0_0093;
        pmem_resp  = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (got_resp(e.is_data) !== exp_resp(e)) begin
            n_fail++;
            $display("FAIL fetch_resp: got %h, expected %h", got_resp(e.is_data), exp_resp(e));
        end
        tick();
        pmem_resp = 1'b0;
        inst_read = 1'b0;
        n_checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL fetch_release: got %b, expected 00", {pmem_read, pmem_write});
        end
        tick();
    endtask

    task automatic test_lone_store();
        txn_t e;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 32'h1234_5678));
        data_addr        = 32'h0000_0100;
        data_wdata       = 32'hDEAD_BEEF;
        data_byte_enable = 4'b0011;
        data_write       = 1'b1;
        tick();
        e = exp_q[0];
        n_checks++;
        if (got_vec(e.wr) !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL store_issue: got %h, expected %h", got_vec(e.wr), exp_vec(e));
        end
        pmem_rdata = 32'h1234_5678;
        pmem_resp  = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (got_resp(e.is_data) !== exp_resp(e)) begin
            n_fail++;
            $display("FAIL store_resp: got %h, expected %h", got_resp(e.is_data), exp_resp(e));
        end
        tick();
        n_checks++;
        if ({inst_resp, data_resp, pmem_read, pmem_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL store_single_pulse: got %b, expected 0000",
                     {inst_resp, data_resp, pmem_read, pmem_write});
        end
        pmem_resp  = 1'b0;
        data_write = 1'b0;
        tick();
    endtask

    task automatic test_read_write_both();
        txn_t e;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'b1100, 32'h0F0F_0F0F));
        data_addr        = 32'h0000_0044;
        data_wdata       = 32'hA5A5_A5A5;
        data_byte_enable = 4'b1100;
        data_read        = 1'b1;
        data_write       = 1'b1;
        tick();
        e = exp_q[0];
        n_checks++;
        if (got_vec(e.wr) !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL rw_is_write: got %h, expected %h", got_vec(e.wr), exp_vec(e));
        end
        pmem_rdata = 32'h0F0F_0F0F;
        pmem_resp  = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (got_resp(e.is_data) !== exp_resp(e)) begin
            n_fail++;
            $display("FAIL rw_resp: got %h, expected %h", got_resp(e.is_data), exp_resp(e));
        end
        tick();
        pmem_resp  = 1'b0;
        data_read  = 1'b0;
        data_write = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        txn_t e;
        reset = 1'b0;
        tick();
        reset            = 1'b1;
        inst_addr        = 32'h0000_0060;
        inst_read        = 1'b1;
        data_addr        = 32'h0000_0200;
        data_byte_enable = 4'b0101;
        data_read        = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h1111_1111));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'hF, 32'h2222_2222));
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 32'h3333_3333));
        for (int k = 0; k < 3; k++) begin
            tick();
            e = exp_q[0];
            n_checks++;
            if (got_vec(e.wr) !== exp_vec(e)) begin
                n_fail++;
                $display("FAIL contend_grant%0d: got %h, expected %h", k, got_vec(e.wr), exp_vec(e));
            end
            pmem_rdata = e.rdata;
            pmem_resp  = 1'b1;
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (got_resp(e.is_data) !== exp_resp(e)) begin
                n_fail++;
                $display("FAIL contend_resp%0d: got %h, expected %h", k, got_resp(e.is_data), exp_resp(e));
            end
            tick();
            pmem_resp = 1'b0;
            n_checks++;
            if ({pmem_read, pmem_write} !== 2'b00) begin
                n_fail++;
                $display("FAIL contend_idle%0d: got %b, expected 00", k, {pmem_read, pmem_write});
            end
        end
        inst_read = 1'b0;
        data_read = 1'b0;
        tick();
    endtask

    task automatic test_midchange();
        txn_t e;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hCAFE_F00D));
        data_addr        = 32'h0000_0100;
        data_byte_enable = 4'hF;
        data_read        = 1'b1;
        tick();
        e = exp_q[0];
        n_checks++;
        if (got_vec(e.wr) !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL midchange_issue: got %h, expected %h", got_vec(e.wr), exp_vec(e));
        end
        data_addr = 32'h0000_0200;
        data_read = 1'b0;
        tick();
        tick();
        n_checks++;
        if (got_vec(e.wr) !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL midchange_hold: got %h, expected %h", got_vec(e.wr), exp_vec(e));
        end
        pmem_rdata = 32'hCAFE_F00D;
        pmem_resp  = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (got_resp(e.is_data) !== exp_resp(e)) begin
            n_fail++;
            $display("FAIL midchange_resp: got %h, expected %h", got_resp(e.is_data), exp_resp(e));
        end
        tick();
        pmem_resp = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        inst_addr = 32'h0000_0060;
        inst_read = 1'b1;
        tick();
        n_checks++;
        if ({pmem_read, pmem_addr} !== {1'b1, 32'h0000_0060}) begin
            n_fail++;
            $display("FAIL rstmid_grant: got %b/%h, expected 1/00000060", pmem_read, pmem_addr);
        end
        reset     = 1'b0;
        inst_read = 1'b0;
        tick();
        n_checks++;
        if ({got_vec(1'b1), inst_resp, data_resp} !== 72'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got %h, expected 0", {got_vec(1'b1), inst_resp, data_resp});
        end
        reset = 1'b1;
        tick();
        pmem_rdata = 32'hFFFF_FFFF;
        pmem_resp  = 1'b1;
        #1;
        n_checks++;
        if ({inst_resp, data_resp} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_stray: got %b, expected 00", {inst_resp, data_resp});
        end
        tick();
        pmem_resp = 1'b0;
        n_checks++;
        if (got_vec(1'b1) !== 70'h0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %h, expected 0", got_vec(1'b1));
        end
        tick();
    endtask

    task automatic test_stray();
        txn_t e;
        pmem_rdata = 32'h5555_AAAA;
        pmem_resp  = 1'b1;
        #1;
        n_checks++;
        if ({inst_resp, data_resp} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_resp: got %b, expected 00", {inst_resp, data_resp});
        end
        tick();
        tick();
        n_checks++;
        if ({got_vec(1'b1), inst_resp, data_resp} !== 72'h0) begin
            n_fail++;
            $display("FAIL stray_state: got %h, expected 0", {got_vec(1'b1), inst_resp, data_resp});
        end
        pmem_resp = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 32'h0BAD_F00D));
        inst_addr = 32'h0000_0080;
        inst_read = 1'b1;
        tick();
        e = exp_q[0];
        n_checks++;
        if (got_vec(e.wr) !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL stray_next_issue: got %h, expected %h", got_vec(e.wr), exp_vec(e));
        end
        pmem_rdata = 32'h0BAD_F00D;
        pmem_resp  = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (got_resp(e.is_data) !== exp_resp(e)) begin
            n_fail++;
            $display("FAIL stray_next_resp: got %h, expected %h", got_resp(e.is_data), exp_resp(e));
        end
        tick();
        pmem_resp = 1'b0;
        inst_read = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_lone_store();
        test_read_write_both();
        test_contention();
        test_midchange();
        test_reset_mid();
        test_stray();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
